s2_sequencer: RTL and testbench

Top-level sequencer for convolution stage 2. On a `start` pulse it streams the 8×8×3 input tensor out of the stage-1 result BRAM into the tensor builder. It then steps the processing datapath through 4 filters × 36 output positions (6×6) with a valid/ready handshake, and pulses `done` when all 144 outputs have been issued. It drives the BRAM read port, the tensor-builder write coordinates, the filter select for the filter mux, and the output address.

---
 rtl/s2_sequencer.sv | 177 +++++++++++++++++
 tb/tb_s2_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/s2_sequencer.sv
// Convolution stage-2 sequencer: loads the 8x8x3 tensor from the stage-1 BRAM,
// then steps the datapath through 4 filters x 6x6 output positions.
module s2_sequencer #(
  parameter int IN_DIM  = 8,
  parameter int N_CHA   = 3,
  parameter int N_FILT  = 4,
  parameter int OUT_DIM = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       enable_read,
  output logic [7:0] read_addr,
  output logic       load_we,
  output logic [2:0] row_addr,
  output logic [2:0] col_addr,
  output logic [1:0] cha_addr,
  output logic [1:0] filter_sel,
  output logic [2:0] out_row,
  output logic [2:0] out_col,
  output logic       out_valid,
  output logic [7:0] out_addr
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_PROC, S_DONE} state_t;

  localparam logic [7:0] LAST_RD  = 8'(IN_DIM * IN_DIM * N_CHA - 1);
  localparam logic [7:0] LAST_OUT = 8'(N_FILT * OUT_DIM * OUT_DIM - 1);
  localparam logic [2:0] LAST_POS = 3'(OUT_DIM - 1);

  state_t     state_q, state_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       enable_read_q, enable_read_d;
  logic [7:0] rd_q, rd_d;
  logic       load_we_q, load_we_d;
  logic [2:0] row_addr_q, row_addr_d;
  logic [2:0] col_addr_q, col_addr_d;
  logic [1:0] cha_addr_q, cha_addr_d;
  logic [1:0] filter_q, filter_d;
  logic [2:0] out_row_q, out_row_d;
  logic [2:0] out_col_q, out_col_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_addr_q, out_addr_d;

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    enable_read_d = enable_read_q;
    rd_d          = rd_q;
    filter_d      = filter_q;
    out_row_d     = out_row_q;
    out_col_d     = out_col_q;
    out_valid_d   = out_valid_q;
    out_addr_d    = out_addr_q;

    // Write coordinates are the issued read address delayed by the BRAM latency.
    load_we_d  = (state_q == S_LOAD);
    cha_addr_d = load_we_d ? rd_q[7:6] : '0;
    row_addr_d = load_we_d ? rd_q[5:3] : '0;
    col_addr_d = load_we_d ? rd_q[2:0] : '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_LOAD;
          busy_d        = 1'b1;
          enable_read_d = 1'b1;
          rd_d          = '0;
        end
      end
      S_LOAD: begin
        if (rd_q == LAST_RD) begin
          state_d       = S_DRAIN;
          enable_read_d = 1'b0;
          rd_d          = '0;
        end else begin
          rd_d = rd_q + 8'd1;
        end
      end
      S_DRAIN: begin
        state_d     = S_PROC;
        out_valid_d = 1'b1;
        filter_d    = '0;
        out_row_d   = '0;
        out_col_d   = '0;
        out_addr_d  = '0;
      end
      S_PROC: begin
        if (out_ready) begin
          if (out_addr_q == LAST_OUT) begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            out_valid_d = 1'b0;
            filter_d    = '0;
            out_row_d   = '0;
            out_col_d   = '0;
            out_addr_d  = '0;
          end else begin
            out_addr_d = out_addr_q + 8'd1;
            if (out_col_q == LAST_POS) begin
              out_col_d = '0;
              if (out_row_q == LAST_POS) begin
                out_row_d = '0;
                filter_d  = filter_q + 2'd1;
              end else begin
                out_row_d = out_row_q + 3'd1;
              end
            end else begin
              out_col_d = out_col_q + 3'd1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      enable_read_q <= 1'b0;
      rd_q          <= '0;
      load_we_q     <= 1'b0;
      row_addr_q    <= '0;
      col_addr_q    <= '0;
      cha_addr_q    <= '0;
      filter_q      <= '0;
      out_row_q     <= '0;
      out_col_q     <= '0;
      out_valid_q   <= 1'b0;
      out_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      enable_read_q <= enable_read_d;
      rd_q          <= rd_d;
      load_we_q     <= load_we_d;
      row_addr_q    <= row_addr_d;
      col_addr_q    <= col_addr_d;
      cha_addr_q    <= cha_addr_d;
      filter_q      <= filter_d;
      out_row_q     <= out_row_d;
      out_col_q     <= out_col_d;
      out_valid_q   <= out_valid_d;
      out_addr_q    <= out_addr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign enable_read = enable_read_q;
  assign read_addr   = rd_q;
  assign load_we     = load_we_q;
  assign row_addr    = row_addr_q;
  assign col_addr    = col_addr_q;
  assign cha_addr    = cha_addr_q;
  assign filter_sel  = filter_q;
  assign out_row     = out_row_q;
  assign out_col     = out_col_q;
  assign out_valid   = out_valid_q;
  assign out_addr    = out_addr_q;

endmodule

// File: tb/tb_s2_sequencer.sv
// Bench for s2_sequencer: a cycle/beat-count reference model predicts every
// output each cycle; directed frames check timing, stalls, ignored starts and reset.
module tb_s2_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, out_ready;
  logic       busy, done, enable_read, load_we, out_valid;
  logic [7:0] read_addr, out_addr;
  logic [2:0] row_addr, col_addr, out_row, out_col;
  logic [1:0] cha_addr, filter_sel;

  s2_sequencer #(.IN_DIM(8), .N_CHA(3), .N_FILT(4), .OUT_DIM(6)) dut (
    .clk(clk), .reset(reset), .start(start), .out_ready(out_ready),
    .busy(busy), .done(done), .enable_read(enable_read), .read_addr(read_addr),
    .load_we(load_we), .row_addr(row_addr), .col_addr(col_addr), .cha_addr(cha_addr),
    .filter_sel(filter_sel), .out_row(out_row), .out_col(out_col),
    .out_valid(out_valid), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: m_t = cycles since start (1..194, held at 194 while processing),
  // m_b = beats accepted so far.
  bit m_frame = 1'b0;
  bit m_done  = 1'b0;
  int m_t     = 0;
  int m_b     = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [31:0] e_rd, e_ld, e_pr, e_st;
    int a;
    e_rd = '0; e_ld = '0; e_pr = '0;
    if (m_frame && m_t <= 192) e_rd = 32'h100 | 32'(m_t - 1);
    if (m_frame && m_t >= 2 && m_t <= 193) begin
      a = m_t - 2;
      e_ld = 32'h100 | 32'((a / 64) * 64 + ((a / 8) % 8) * 8 + (a % 8));
    end
    if (m_frame && m_t >= 194)
      e_pr = (32'd1 << 16) | (32'(m_b / 36) << 14) | (32'((m_b % 36) / 6) << 11)
           | (32'(m_b % 6) << 8) | 32'(m_b);
    e_st = {30'd0, m_frame, m_done};
    check_eq("read", {23'd0, enable_read, read_addr}, e_rd);
    check_eq("load", {23'd0, load_we, cha_addr, row_addr, col_addr}, e_ld);
    check_eq("proc", {15'd0, out_valid, filter_sel, out_row, out_col, out_addr}, e_pr);
    check_eq("status", {30'd0, busy, done}, e_st);
  endtask

  task automatic step(input logic r, input logic s, input logic rdy);
    reset = r; start = s; out_ready = rdy;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      m_frame = 1'b0; m_done = 1'b0; m_t = 0; m_b = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_frame) begin
      if (s) begin m_frame = 1'b1; m_t = 1; m_b = 0; end
    end else if (m_t < 194) begin
      m_t++;
    end else if (rdy) begin
      m_b++;
      if (m_b == 144) begin m_frame = 1'b0; m_done = 1'b1; end
    end
    compare_all();
  endtask

  // mode 0: ready high; 1: extra starts in LOAD/PROC; 2: directed stalls; 3: random ready
  task automatic run_frame(input int mode, output int delta, output int stalls);
    int  c0, s20, s143;
    bit  got, s, rdy, in_proc;
    c0 = cyc; s20 = 0; s143 = 0; stalls = 0; got = 0; delta = -1;
    step(1'b0, 1'b1, 1'b1);
    check_eq("first_read", {23'd0, enable_read, read_addr}, 32'h100);
    for (int i = 0; i < 2000 && !got; i++) begin
      s = 1'b0; rdy = 1'b1;
      in_proc = m_frame && m_t >= 194;
      if (mode == 1) s = (m_t == 50) || (in_proc && m_b == 70);
      if (mode == 2 && in_proc) begin
        if (m_b == 20 && s20 < 5) begin rdy = 1'b0; s20++; end
        else if (m_b == 143 && s143 < 1) begin rdy = 1'b0; s143++; end
      end
      if (mode == 3) rdy = 1'($urandom_range(0, 1));
      if (in_proc && !rdy) stalls++;
      step(1'b0, s, rdy);
      if (done) begin got = 1'b1; delta = cyc - c0; end
    end
    if (!got) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int d, st;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Basic frame
    run_frame(0, d, st);
    check_eq("done_latency", 32'(d), 32'd338);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Extra starts in LOAD, PROC and DONE are ignored
    run_frame(1, d, st);
    check_eq("ignore_latency", 32'(d), 32'd338);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);

    // Backpressure
    run_frame(2, d, st);
    check_eq("stall_count", 32'(st), 32'd6);
    check_eq("stall_latency", 32'(d), 32'd344);
    step(1'b0, 1'b0, 1'b0);

    // Random ready everywhere
    run_frame(3, d, st);
    check_eq("rand_latency", 32'(d), 32'(338 + st));
    step(1'b0, 1'b0, 1'b1);

    // Mid-load reset at read address 100
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 300 && !(m_frame && m_t == 101); i++) step(1'b0, 1'b0, 1'b1);
    check_eq("reached_rd100", {24'd0, read_addr}, 32'd100);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    run_frame(0, d, st);
    check_eq("post_reset_latency", 32'(d), 32'd338);

    // Back-to-back: start in first IDLE cycle after done
    step(1'b0, 1'b0, 1'b1);
    run_frame(0, d, st);
    check_eq("b2b_latency", 32'(d), 32'd338);

    // Mid-processing reset
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 300 && !(m_frame && m_t == 194 && m_b == 60); i++) step(1'b0, 1'b0, 1'b1);
    check_eq("reached_beat60", {24'd0, out_addr}, 32'd60);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
